snes_pad_responder: RTL and testbench
=====================================

Name: snes_pad_responder

Overview:
- Controller-side (device) end of the SNES serial pad interface; a drop-in replacement for a physical pad, driven by any SNES-protocol host (console or our own pad reader).
- Snapshots a 16-bit button word while the host holds latch high, then shifts it out serially, active-low, one bit per pulse rising edge.
- Sits between on-chip button sources (test/replay logic, remote input) and the pad connector pins.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on latch and pulse inputs.
- FILTER_CYCLES, 4, consecutive stable synced cycles required before a latch/pulse level change is accepted.
- TIMEOUT_CYCLES, 100000, idle cycles in SHIFT before the frame is aborted (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-low reset.
- latch  in  1  host latch pin, asynchronous.
- pulse  in  1  host clock pin, asynchronous.
- buttons  in  16  pressed=1, packed {N3,N2,N1,N0,left,right,up,down,A,B,X,Y,L,R,select,start} (bit15..bit0).
- data  out  1  serial data pin, registered, low = pressed.
- busy  out  1  high in LOAD or SHIFT.
- frame_done  out  1  one-cycle strobe, all 16 bits presented.
- frame_err  out  1  one-cycle strobe, frame aborted.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, shift=16'h0000, bit_cnt=0, timer=0, filters at 0, data=1, busy=0, frame_done=0, frame_err=0.
- Input path: SYNC_STAGES flops, then filter; filtered level changes only after FILTER_CYCLES equal consecutive samples. Edge detect on filtered signals.
- Serial order, bit 0 first: B(6), Y(4), select(1), start(0), up(9), down(8), left(11), right(10), A(7), X(5), L(3), R(2), N0(12), N1(13), N2(14), N3(15). Numbers are buttons indices.
- data is registered and equals ~shift[0] at all times.
- Worst-case pin-edge to data-change latency: SYNC_STAGES+FILTER_CYCLES+1 clk (7 cycles at defaults).
- IDLE: on latch_f rise, go to LOAD.
- LOAD: every cycle, shift <= reordered buttons. Pulses are ignored. On latch_f fall, go to SHIFT with bit_cnt=0 and timer=0.
- SHIFT, on pulse_f rise:
  - shift <= {1'b1, shift[15:1]}, so the fill drives the line low.
  - bit_cnt++ and timer=0.
  - When bit_cnt becomes 15, pulse frame_done and go to DONE.
- SHIFT, otherwise: timer++. When timer reaches TIMEOUT_CYCLES-1, pulse frame_err and go to IDLE; shift is retained.
- DONE: pulse_f rises still shift fill 1s; after 16 total pulses data=0 permanently until reload. No timeout in DONE.
- latch_f rise in any state goes to LOAD. If it arrives in SHIFT, also pulse frame_err that cycle.
- latch_f rise and pulse_f rise in the same cycle: latch wins and the pulse is dropped.
- bit_cnt saturates at 15; no wrap.
- Glitches shorter than FILTER_CYCLES on either pin produce no state change.
- Reset asserted mid-frame returns everything to reset values on the next clk edge, and data goes high.

Decomposition:
- Package snes_pad_pkg contains:
  - state encodings IDLE/LOAD/SHIFT/DONE;
  - the SNES_BIT_ORDER index constant (16 entries above);
  - the bit-count constant 16.
- The host-side pad reader imports the same package for the button packing.
- Sub-module snes_sync_filter (SYNC_STAGES, FILTER_CYCLES) produces level/rise/fall; instantiate it twice (latch, pulse).

Test Plan:
- Reset check: hold rst=0 for 5 clk -> data=1, busy=0, no strobes, state IDLE.
- Full frame: buttons=16'h0040 (B only), 12 us latch, then 15 pulses of 6 us high/6 us low.
  - data=0 for bit 0 and 1 for bits 1-15.
  - frame_done asserts exactly once, after pulse 15.
  - Our pad reader returns plyr_input=16'h0040.
- Ordering: buttons=16'hA5C3 through a full frame -> serial sequence matches SNES_BIT_ORDER and the reader returns 16'hA5C3. Also, a 16th pulse drives data=0 and a 17th keeps it 0.
- Glitch rejection: 2-cycle pulses on latch, and 3-cycle pulses on pulse during SHIFT -> no reload, no shift, data unchanged.
- Abort by latch: latch rises after pulse 7 -> frame_err one cycle, reload with new buttons=16'hFFFF; after latch falls, data=0.
- Timeout: stop pulses after pulse 3 -> frame_err exactly TIMEOUT_CYCLES cycles after the last filtered pulse rise, state IDLE, busy=0. Then assert rst=0 mid-LOAD -> data=1 next cycle.

Source files
------------

// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES pad interface: FSM states, serial bit order
// and the button-word packing used by both the responder and the host reader.
package snes_pad_pkg;

    localparam int SNES_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } pad_state_t;

    // Entry i is the button index presented on serial bit i (B first, N3 last).
    localparam logic [3:0] SNES_BIT_ORDER [SNES_BITS] = '{
        4'd6,  4'd4,  4'd1,  4'd0,
        4'd9,  4'd8,  4'd11, 4'd10,
        4'd7,  4'd5,  4'd3,  4'd2,
        4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [SNES_BITS-1:0] snes_pack(input logic [SNES_BITS-1:0] buttons);
        logic [SNES_BITS-1:0] serial;
        serial = '0;
        for (int i = 0; i < SNES_BITS; i++) begin
            serial[i] = buttons[SNES_BIT_ORDER[i]];
        end
        return serial;
    endfunction

    function automatic logic [SNES_BITS-1:0] snes_unpack(input logic [SNES_BITS-1:0] serial);
        logic [SNES_BITS-1:0] buttons;
        buttons = '0;
        for (int i = 0; i < SNES_BITS; i++) begin
            buttons[SNES_BIT_ORDER[i]] = serial[i];
        end
        return buttons;
    endfunction

endpackage

// File: rtl/snes_sync_filter.sv
// Synchronizes an asynchronous pad pin and debounces it: the filtered level only
// follows the synced input after FILTER_CYCLES consecutive differing samples.
module snes_sync_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = din;
        cnt_d     = '0;
        level_d   = level_q;
        // Any sample agreeing with the current level restarts the count.
        if (synced != level_q) begin
            if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Device-side SNES pad: snapshots the button word while latch is high and shifts
// it out active-low, one bit per filtered pulse rise, with abort and timeout.
module snes_pad_responder
    import snes_pad_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 latch,
    input  logic                 pulse,
    input  logic [SNES_BITS-1:0] buttons,
    output logic                 data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] CNT_LAST = 4'(SNES_BITS - 1);

    logic latch_lvl, latch_rise, latch_fall;
    logic pulse_lvl, pulse_rise, pulse_fall;
    logic unused_filter_outs;

    snes_sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_latch_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (latch),
        .level(latch_lvl),
        .rise (latch_rise),
        .fall (latch_fall)
    );

    snes_sync_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_pulse_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (pulse),
        .level(pulse_lvl),
        .rise (pulse_rise),
        .fall (pulse_fall)
    );

    assign unused_filter_outs = &{1'b0, latch_lvl, pulse_lvl, pulse_fall};

    pad_state_t           state_q, state_d;
    logic [SNES_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // A latch rise restarts the frame from any state and swallows a coincident pulse.
        if (latch_rise) begin
            state_d = LOAD;
            err_d   = (state_q == SHIFT);
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                LOAD: begin
                    shift_d = snes_pack(buttons);
                    if (latch_fall) begin
                        state_d   = SHIFT;
                        bit_cnt_d = 4'd0;
                        timer_d   = '0;
                    end
                end
                SHIFT: begin
                    if (pulse_rise) begin
                        shift_d   = {1'b1, shift_q[SNES_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        timer_d   = '0;
                        if (bit_cnt_q == CNT_LAST - 4'd1) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                DONE: begin
                    if (pulse_rise) begin
                        shift_d = {1'b1, shift_q[SNES_BITS-1:1]};
                        if (bit_cnt_q != CNT_LAST) begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
            endcase
        end

        data_d = ~shift_d[0];
        busy_d = (state_d == LOAD) || (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= 4'd0;
            timer_q   <= '0;
            data_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign data       = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed, table-driven bench for snes_pad_responder with hand-computed serial words.
module tb_snes_pad_responder;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        latch = 1'b0;
    logic        pulse = 1'b0;
    logic [15:0] buttons = 16'h0000;
    logic        data, busy, frame_done, frame_err;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int last_chg = 0;
    int err_cyc = 0;
    logic prev_data = 1'b1;

    typedef struct {
        logic [15:0] btn;
        logic [15:0] ser;
    } vec_t;

    vec_t vecs[8];
    int   ord[16];

    always #5 clk = ~clk;

    snes_pad_responder #(
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .latch     (latch),
        .pulse     (pulse),
        .buttons   (buttons),
        .data      (data),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    always begin
        @(posedge clk);
        #2;
        cyc = cyc + 1;
        if (frame_done === 1'b1) done_cnt = done_cnt + 1;
        if (frame_err === 1'b1) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (data !== prev_data) begin
            last_chg  = cyc;
            prev_data = data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_once();
        pulse = 1'b1;
        cycles(12);
        pulse = 1'b0;
        cycles(12);
    endtask

    task automatic latch_frame(input logic [15:0] btn);
        buttons = btn;
        latch = 1'b1;
        cycles(24);
        latch = 1'b0;
        cycles(12);
    endtask

    logic [15:0] ser, rec;
    int d0, e0;

    initial begin
        // {buttons, expected pressed-bit serial word (bit i = serial slot i)}
        vecs[0] = '{16'h0040, 16'h0001};
        vecs[1] = '{16'hA5C3, 16'hA1AD};
        vecs[2] = '{16'hFFFF, 16'hFFFF};
        vecs[3] = '{16'h0000, 16'h0000};
        vecs[4] = '{16'h8000, 16'h8000};
        vecs[5] = '{16'h0001, 16'h0008};
        vecs[6] = '{16'h0800, 16'h0040};
        vecs[7] = '{16'h0004, 16'h0800};
        ord = '{6, 4, 1, 0, 9, 8, 11, 10, 7, 5, 3, 2, 12, 13, 14, 15};

        rst = 1'b0;
        cycles(5);
        check("reset_data", data, 1);
        check("reset_busy", busy, 0);
        check("reset_done", frame_done, 0);
        check("reset_err", frame_err, 0);
        rst = 1'b1;
        cycles(2);

        for (int v = 0; v < 8; v++) begin
            d0 = done_cnt;
            buttons = vecs[v].btn;
            latch = 1'b1;
            cycles(24);
            check("busy_load", busy, 1);
            latch = 1'b0;
            cycles(12);
            check("busy_shift", busy, 1);
            ser[0] = ~data;
            for (int k = 1; k < 16; k++) begin
                pulse_once();
                ser[k] = ~data;
                if (k == 14) check("done_early", done_cnt, d0);
            end
            check("serial_word", ser, vecs[v].ser);
            check("done_once", done_cnt, d0 + 1);
            check("busy_done", busy, 0);
            rec = '0;
            for (int i = 0; i < 16; i++) rec[ord[i]] = ser[i];
            check("reader_word", rec, vecs[v].btn);
            pulse_once();
            check("pulse16_data", data, 0);
            pulse_once();
            check("pulse17_data", data, 0);
            check("done_still_once", done_cnt, d0 + 1);
        end

        // Glitch rejection mid-frame: serial A1AD gives data=1 at slot 4, 0 at slot 5.
        e0 = err_cnt;
        latch_frame(16'hA5C3);
        repeat (4) pulse_once();
        check("glitch_pre", data, 1);
        latch = 1'b1;
        cycles(2);
        latch = 1'b0;
        cycles(12);
        check("latch_glitch_data", data, 1);
        check("latch_glitch_busy", busy, 1);
        check("latch_glitch_err", err_cnt, e0);
        pulse = 1'b1;
        cycles(3);
        pulse = 1'b0;
        cycles(12);
        check("pulse_glitch_data", data, 1);
        pulse_once();
        check("post_glitch_shift", data, 0);

        // Abort by latch after pulse 7.
        repeat (2) pulse_once();
        e0 = err_cnt;
        buttons = 16'hFFFF;
        latch = 1'b1;
        cycles(24);
        check("abort_err", err_cnt, e0 + 1);
        check("abort_busy", busy, 1);
        latch = 1'b0;
        cycles(12);
        check("abort_reload_data", data, 0);

        // Timeout: start pressed (slot 3), so data falls on pulse 3.
        latch_frame(16'h0001);
        e0 = err_cnt;
        repeat (3) pulse_once();
        check("tmo_pulse3_data", data, 0);
        cycles(TMO + 20);
        check("tmo_err_once", err_cnt, e0 + 1);
        check("tmo_latency", err_cyc - last_chg, TMO);
        check("tmo_busy", busy, 0);
        check("tmo_data_kept", data, 0);

        // Reset in LOAD.
        buttons = 16'h0040;
        latch = 1'b1;
        cycles(12);
        check("load_busy", busy, 1);
        check("load_data", data, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_data", data, 1);
        check("rst_mid_busy", busy, 0);
        rst = 1'b1;
        latch = 1'b0;
        cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
